// File: rtl/ctrl_decode_pipe.sv
// RV32I main control decoder with a valid/ready output register and redirect kill.
// ILLEGAL_TRAP_EN: an illegal word leaving the register halts the pipe until rst_n.
module ctrl_decode_pipe #(
  parameter int KILL_CNT = 2,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  input  logic        ex_eq,
  input  logic        ex_lt,
  input  logic        ex_ltu,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        mem_write,
  output logic        alu_src,
  output logic [1:0]  alu_a_sel,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_op,
  output logic        branch,
  output logic        jump,
  output logic        pc_src,
  output logic        illegal
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    KILL = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_a_sel;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  localparam logic [CNT_W-1:0] KCNT  = CNT_W'(KILL_CNT);
  localparam logic [CNT_W-1:0] KCNT1 = CNT_W'(KILL_CNT - 1);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  ctrl_t            ctl_q, ctl_d;
  logic             ill_q, ill_d;
  logic [2:0]       f3_q, f3_d;

  ctrl_t      dec;
  logic       dec_ill;
  logic [6:0] op;
  logic [2:0] f3;
  logic       in_xfer;
  logic       out_xfer;
  logic       cond;
  logic       unused_instr;

  assign op           = instr[6:0];
  assign f3           = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    unique case (1'b1)
      op == OP_LD:  dec = {1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
      op == OP_ST:  dec = {1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0};
      op == OP_R:   dec = {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0};
      op == OP_I:   dec = {1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0};
      op == OP_BR: begin
        if (f3[2:1] == 2'b01) dec_ill = 1'b1;
        else dec = {1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b010, 2'b01, 1'b1, 1'b0};
      end
      op == OP_JAL: dec = {1'b1, 2'b10, 1'b0, 1'b1, 2'b01, 3'b011, 2'b00, 1'b0, 1'b1};
      op == OP_JR:  dec = {1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
      op == OP_LUI: dec = {1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 3'b100, 2'b00, 1'b0, 1'b0};
      op == OP_AUI: dec = {1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 3'b100, 2'b00, 1'b0, 1'b0};
      default:      dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (f3_q)
      3'b000:  cond = ex_eq;
      3'b001:  cond = !ex_eq;
      3'b100:  cond = ex_lt;
      3'b101:  cond = !ex_lt;
      3'b110:  cond = ex_ltu;
      3'b111:  cond = !ex_ltu;
      default: cond = 1'b0;
    endcase
  end

  assign in_ready = (!vld_q | out_ready) & (st_q != HALT);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = vld_q & out_ready;
  assign pc_src   = out_xfer & (ctl_q.jump | (ctl_q.branch & cond));

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    ctl_d = ctl_q;
    ill_d = ill_q;
    f3_d  = f3_q;
    if (out_xfer) vld_d = 1'b0;
    if (st_q == HALT) begin
      vld_d = 1'b0;
    end else if (flush) begin
      vld_d = 1'b0;
      cnt_d = '0;
      st_d  = RUN;
`ifdef ILLEGAL_TRAP_EN
    end else if (out_xfer & ill_q) begin
      vld_d = 1'b0;
      cnt_d = '0;
      st_d  = HALT;
`endif
    end else if (st_q == KILL) begin
      if (in_xfer) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) st_d = RUN;
      end
    end else if (pc_src) begin
      // a word accepted alongside the redirect is already wrong-path
      if (in_xfer) begin
        cnt_d = KCNT1;
        st_d  = (KCNT1 == '0) ? RUN : KILL;
      end else begin
        cnt_d = KCNT;
        st_d  = KILL;
      end
    end else if (in_xfer) begin
      vld_d = 1'b1;
      ctl_d = dec;
      ill_d = dec_ill;
      f3_d  = f3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RUN;
      cnt_q <= '0;
      vld_q <= 1'b0;
      ctl_q <= '0;
      ill_q <= 1'b0;
      f3_q  <= 3'b000;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      ctl_q <= ctl_d;
      ill_q <= ill_d;
      f3_q  <= f3_d;
    end
  end

  assign out_valid  = vld_q;
  assign illegal    = ill_q;
  assign reg_write  = ctl_q.reg_write;
  assign result_src = ctl_q.result_src;
  assign mem_write  = ctl_q.mem_write;
  assign alu_src    = ctl_q.alu_src;
  assign alu_a_sel  = ctl_q.alu_a_sel;
  assign imm_src    = ctl_q.imm_src;
  assign alu_op     = ctl_q.alu_op;
  assign branch     = ctl_q.branch;
  assign jump       = ctl_q.jump;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode, back-pressure, redirect kill,
// flush and illegal handling, with immediate-assertion checks.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        ex_eq;
  logic        ex_lt;
  logic        ex_ltu;
  logic        reg_write;
  logic [1:0]  result_src;
  logic        mem_write;
  logic        alu_src;
  logic [1:0]  alu_a_sel;
  logic [2:0]  imm_src;
  logic [1:0]  alu_op;
  logic        branch;
  logic        jump;
  logic        pc_src;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI  = 32'h00A00093;
  localparam logic [31:0] ADDI2 = 32'h00100113;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] BNE   = 32'h00209463;
  localparam logic [31:0] JAL   = 32'h0080006F;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] BBAD  = 32'h0020A063;
  localparam logic [31:0] ILL   = 32'h0000007F;

  ctrl_decode_pipe #(.KILL_CNT(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .ex_eq(ex_eq), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .reg_write(reg_write), .result_src(result_src),
    .mem_write(mem_write), .alu_src(alu_src), .alu_a_sel(alu_a_sel),
    .imm_src(imm_src), .alu_op(alu_op), .branch(branch), .jump(jump),
    .pc_src(pc_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    flush = 1'b0; ex_eq = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0;
    tick(); tick();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst reg_write", 32'(reg_write), 32'd0);
    chk("rst result_src", 32'(result_src), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // addi
    in_valid = 1'b1; instr = ADDI; out_ready = 1'b1;
    tick();
    chk("addi out_valid", 32'(out_valid), 32'd1);
    chk("addi reg_write", 32'(reg_write), 32'd1);
    chk("addi alu_src", 32'(alu_src), 32'd1);
    chk("addi alu_op", 32'(alu_op), 32'd3);
    chk("addi imm_src", 32'(imm_src), 32'd0);
    chk("addi illegal", 32'(illegal), 32'd0);
    chk("addi pc_src", 32'(pc_src), 32'd0);

    // load under back-pressure
    instr = LW;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp result_src", 32'(result_src), 32'd1);
      chk("bp reg_write", 32'(reg_write), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp one transfer", 32'(out_valid), 32'd0);

    // beq taken: next two accepted are killed
    in_valid = 1'b1; instr = BEQ; out_ready = 1'b0;
    tick();
    chk("beq branch", 32'(branch), 32'd1);
    chk("beq imm_src", 32'(imm_src), 32'd2);
    chk("beq alu_op", 32'(alu_op), 32'd1);
    instr = ADDI; ex_eq = 1'b1; out_ready = 1'b1;
    #1;
    chk("beq pc_src on", 32'(pc_src), 32'd1);
    tick();
    chk("beq pc_src pulse", 32'(pc_src), 32'd0);
    chk("kill1 out_valid", 32'(out_valid), 32'd0);
    instr = ADDI2;
    tick();
    chk("kill2 out_valid", 32'(out_valid), 32'd0);
    instr = LUI; ex_eq = 1'b0;
    tick();
    chk("third out_valid", 32'(out_valid), 32'd1);
    chk("lui alu_a_sel", 32'(alu_a_sel), 32'd2);
    chk("lui imm_src", 32'(imm_src), 32'd4);

    // bne not taken, then jal
    instr = BNE;
    tick();
    in_valid = 1'b0; ex_eq = 1'b1;
    #1;
    chk("bne branch", 32'(branch), 32'd1);
    chk("bne pc_src", 32'(pc_src), 32'd0);
    in_valid = 1'b1; instr = JAL;
    tick();
    chk("jal out_valid", 32'(out_valid), 32'd1);
    chk("jal result_src", 32'(result_src), 32'd2);
    chk("jal imm_src", 32'(imm_src), 32'd3);
    chk("jal alu_a_sel", 32'(alu_a_sel), 32'd1);
    chk("jal jump", 32'(jump), 32'd1);
    chk("jal pc_src", 32'(pc_src), 32'd1);
    in_valid = 1'b0; ex_eq = 1'b0;
    tick();
    chk("jal drained", 32'(out_valid), 32'd0);

    // flush in KILL with counter 1
    in_valid = 1'b1; instr = ADDI;
    tick();
    chk("kill disc out_valid", 32'(out_valid), 32'd0);
    flush = 1'b1;
    tick();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; instr = SW;
    tick();
    chk("post-flush out_valid", 32'(out_valid), 32'd1);
    chk("sw mem_write", 32'(mem_write), 32'd1);
    chk("sw imm_src", 32'(imm_src), 32'd1);
    chk("sw reg_write", 32'(reg_write), 32'd0);

    // flush together with a taken jump
    instr = JAL;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; instr = ADDI;
    tick();
    chk("flush+jal no kill", 32'(out_valid), 32'd1);
    chk("flush+jal reg_write", 32'(reg_write), 32'd1);

    // illegal opcode
    instr = ILL;
    tick();
    chk("ill out_valid", 32'(out_valid), 32'd1);
    chk("ill illegal", 32'(illegal), 32'd1);
    chk("ill reg_write", 32'(reg_write), 32'd0);
    chk("ill mem_write", 32'(mem_write), 32'd0);
    chk("ill jump", 32'(jump), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    in_valid = 1'b0;
    tick();
    chk("halt in_ready", 32'(in_ready), 32'd0);
    chk("halt out_valid", 32'(out_valid), 32'd0);
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("halt flush ignored", 32'(in_ready), 32'd0);
    chk("halt out_valid2", 32'(out_valid), 32'd0);
    in_valid = 1'b0; rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("halt exit in_ready", 32'(in_ready), 32'd1);
`else
    instr = BBAD;
    tick();
    chk("bbad out_valid", 32'(out_valid), 32'd1);
    chk("bbad illegal", 32'(illegal), 32'd1);
    chk("bbad branch", 32'(branch), 32'd0);
    instr = ADDI;
    tick();
    chk("ill continue valid", 32'(out_valid), 32'd1);
    chk("ill continue illegal", 32'(illegal), 32'd0);
    chk("ill continue in_ready", 32'(in_ready), 32'd1);
`endif

    // asynchronous reset with a word held
    in_valid = 1'b1; instr = LW; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result_src", 32'(result_src), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Next-generation main control decoder for the RV32I core: full base-opcode decode (load, store, R, I-ALU, branch, JAL, JALR, LUI, AUIPC) into a wider control word.
- Control word is held in a valid/ready-handshaked pipeline register between decode and execute.
- Resolves branch/jump redirect from EX comparator flags and squashes wrong-path instructions with a kill counter.

Parameters:
- KILL_CNT, 2, number of accepted input instructions discarded after a taken redirect; legal range 1..7.
- CNT_W, 3, kill-counter width; must satisfy 2**CNT_W > KILL_CNT.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder can accept this cycle.
- instr  in  32  instruction word; bits [6:0] opcode, [14:12] funct3.
- out_valid  out  1  control word valid toward EX.
- out_ready  in  1  EX accepts the control word.
- flush  in  1  external flush, synchronous.
- ex_eq  in  1  rs1 == rs2 for the word currently on the output.
- ex_lt  in  1  signed rs1 < rs2.
- ex_ltu  in  1  unsigned rs1 < rs2.
- reg_write  out  1  write rd.
- result_src  out  2  00 ALU, 01 memory, 10 PC+4.
- mem_write  out  1  store.
- alu_src  out  1  operand B: 0 = rs2, 1 = immediate.
- alu_a_sel  out  2  operand A: 00 = rs1, 01 = PC, 10 = zero.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_op  out  2  00 add, 01 compare/sub, 10 R-funct, 11 I-funct.
- branch  out  1  conditional branch.
- jump  out  1  JAL/JALR.
- pc_src  out  1  redirect taken (combinational from the output register and ex_* flags, gated by transfer).
- illegal  out  1  registered illegal-instruction flag.

Behaviour:
- Reset: out_valid = 0, illegal = 0, all control fields = 0, state RUN, kill counter = 0.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - in_ready = (!out_valid | out_ready) & (state != HALT).
- Register load: on an input transfer the register loads the decoded word in the same cycle, so latency is 1 cycle.
- Hold: if out_valid & !out_ready, the register holds all fields stable.
- Decode table (reg_write / result_src / mem_write / alu_src / alu_a_sel / imm_src / alu_op / branch / jump):
  - 0000011 load: 1/01/0/1/00/000/00/0/0
  - 0100011 store: 0/00/1/1/00/001/00/0/0
  - 0110011 R: 1/00/0/0/00/000/10/0/0
  - 0010011 I: 1/00/0/1/00/000/11/0/0
  - 1100011 B: 0/00/0/0/00/010/01/1/0
  - 1101111 JAL: 1/10/0/1/01/011/00/0/1
  - 1100111 JALR: 1/10/0/1/00/000/00/0/1
  - 0110111 LUI: 1/00/0/1/10/100/00/0/0
  - 0010111 AUIPC: 1/00/0/1/01/100/00/0/0
- Illegal: any other opcode, or a branch with funct3 010/011. Illegal decodes as all-zero control with illegal = 1.
- Branch condition (taken) by funct3:
  - 000: eq
  - 001: !eq
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
- pc_src = output transfer & (jump | (branch & cond)); asserted only in the cycle of that transfer.
- FSM states: RUN, KILL, HALT.
  - RUN -> KILL when pc_src = 1. The kill counter loads KILL_CNT; an input transfer in the same cycle is discarded and counts as 1.
  - KILL: each input transfer is accepted but discarded (out_valid is not set) and decrements the counter. At 0 -> RUN.
  - HALT: see Optional Feature.
- flush: in any state except HALT, out_valid <= 0, counter <= 0, state <= RUN. Any concurrent input is discarded. flush has priority over a taken redirect.
- Asynchronous rst_n has priority over everything, including mid-KILL and HALT.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: when an illegal word makes its output transfer, the FSM enters HALT. In HALT, in_ready = 0 and out_valid = 0, and flush is ignored. Only rst_n exits HALT.
- Undefined: an illegal word passes as a NOP with illegal = 1, and the FSM is unaffected.

Test Plan:
- Reset then instr 0x00A00093 (addi) with out_ready = 1: next cycle out_valid = 1, reg_write = 1, alu_src = 1, alu_op = 11, imm_src = 000, illegal = 0.
- Back-pressure: load 0x0000A103 with out_ready = 0 for 3 cycles: in_ready = 0, fields held (result_src = 01). Raise out_ready: one transfer.
- beq 0x00208463 with ex_eq = 1, KILL_CNT = 2:
  - pc_src pulses exactly 1 cycle.
  - The next 2 accepted instructions produce no out_valid.
  - The 3rd appears.
- bne 0x00209463 with ex_eq = 1: pc_src = 0, no kill; JAL 0x0080006F: pc_src = 1, result_src = 10, imm_src = 011.
- flush asserted in KILL with counter = 1: state returns to RUN, and the next accepted instruction is output. flush with a taken redirect in the same cycle: no KILL entered.
- Opcode 0x0000007F:
  - Without ILLEGAL_TRAP_EN: illegal = 1, all writes 0, pipeline continues.
  - With ILLEGAL_TRAP_EN: in_ready = 0 until rst_n.
